nor_mask_filt: RTL and testbench



---
 rtl/nor_mask_filt.sv | 101 ++++++++++
 tb/tb_nor_mask_filt.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nor_mask_filt.sv
// WIDTH-input NOR with per-input inversion mask, optional input pipeline and a
// registered, glitch-filtered output with valid (OV) and change (CHG) flags.
module nor_mask_filt #(
    parameter int                 WIDTH    = 5,
    parameter logic [WIDTH-1:0]   INV_MASK = {WIDTH{1'b1}},
    parameter int                 PIPE     = 1,
    parameter int                 FILTER   = 2,
    parameter logic               INIT     = 1'b0
) (
    input  logic             C,
    input  logic             CLRN,
    input  logic             CE,
    input  logic [WIDTH-1:0] I,
    output logic             O,
    output logic             OV,
    output logic             CHG
);

    localparam int             CW   = $clog2(FILTER + 2);
    localparam logic [CW-1:0]  CMAX = CW'(FILTER);

    generate
        if (WIDTH < 2 || WIDTH > 64) begin : g_err_width
            $error("nor_mask_filt: WIDTH must be in 2..64");
        end
        if (PIPE < 0 || PIPE > 3) begin : g_err_pipe
            $error("nor_mask_filt: PIPE must be in 0..3");
        end
        if (FILTER < 0 || FILTER > 255) begin : g_err_filter
            $error("nor_mask_filt: FILTER must be in 0..255");
        end
    endgenerate

    logic w_raw;
    logic w_stg;
    logic w_stg_v;

    assign w_raw = ~|(I ^ INV_MASK);

    generate
        if (PIPE == 0) begin : g_nopipe
            assign w_stg   = w_raw;
            assign w_stg_v = 1'b1;
        end else begin : g_pipe
            logic [PIPE-1:0] r_pd;
            logic [PIPE-1:0] r_vld_pipe;

            always_ff @(posedge C or negedge CLRN) begin
                if (!CLRN) begin
                    r_pd       <= '0;
                    r_vld_pipe <= '0;
                end else if (CE) begin
                    r_pd[0]       <= w_raw;
                    r_vld_pipe[0] <= 1'b1;
                    for (int k = 1; k < PIPE; k++) begin
                        r_pd[k]       <= r_pd[k-1];
                        r_vld_pipe[k] <= r_vld_pipe[k-1];
                    end
                end
            end

            assign w_stg   = r_pd[PIPE-1];
            assign w_stg_v = r_vld_pipe[PIPE-1];
        end
    endgenerate

    logic          r_o;
    logic          r_ov;
    logic          r_chg;
    logic [CW-1:0] r_cnt;

    // O flips only after FILTER+1 consecutive valid samples disagree with it;
    // any agreeing sample restarts the count.
    always_ff @(posedge C or negedge CLRN) begin
        if (!CLRN) begin
            r_o   <= INIT;
            r_ov  <= 1'b0;
            r_chg <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_chg <= 1'b0;
            if (CE && w_stg_v) begin
                r_ov <= 1'b1;
                if (w_stg == r_o) begin
                    r_cnt <= '0;
                end else if (r_cnt == CMAX) begin
                    r_o   <= w_stg;
                    r_cnt <= '0;
                    r_chg <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign O   = r_o;
    assign OV  = r_ov;
    assign CHG = r_chg;

endmodule

// File: tb/tb_nor_mask_filt.sv
// Bench for nor_mask_filt: default, INIT=1 and wide/unfiltered instances
// checked against directed expectations and a sample-history reference model.
module tb_nor_mask_filt;

    logic       C = 1'b0;
    logic       CLRN, CE;
    logic [4:0] I;
    logic [7:0] I8;
    logic       O, OV, CHG, O1, OV1, CHG1, O8, OV8, CHG8;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 C = ~C;

    nor_mask_filt u_dut (
        .C(C), .CLRN(CLRN), .CE(CE), .I(I), .O(O), .OV(OV), .CHG(CHG));

    nor_mask_filt #(.INIT(1'b1)) u_init1 (
        .C(C), .CLRN(CLRN), .CE(CE), .I(I), .O(O1), .OV(OV1), .CHG(CHG1));

    nor_mask_filt #(.WIDTH(8), .INV_MASK(8'h00), .PIPE(0), .FILTER(0)) u_wide (
        .C(C), .CLRN(CLRN), .CE(CE), .I(I8), .O(O8), .OV(OV8), .CHG(CHG8));

    // Reference model: index 0 = default, 1 = INIT=1, 2 = wide.
    localparam int MP [3] = '{1, 1, 0};
    localparam int MF [3] = '{2, 2, 0};
    localparam bit MI [3] = '{1'b0, 1'b1, 1'b0};

    bit [3:0] m_hist [3];
    int       m_ns   [3];
    int       m_run  [3];
    bit       m_o    [3];
    bit       m_ov   [3];
    bit       m_chg  [3];

    task automatic model_reset();
        for (int n = 0; n < 3; n++) begin
            m_hist[n] = '0; m_ns[n] = 0; m_run[n] = 0;
            m_o[n] = MI[n]; m_ov[n] = 1'b0; m_chg[n] = 1'b0;
        end
    endtask

    // O takes the staged value once it has disagreed with O for FILTER+1
    // consecutive valid samples; staged data is the raw term PIPE samples old.
    task automatic model_edge(input logic [4:0] i5, input logic [7:0] i8, input logic ce);
        for (int n = 0; n < 3; n++) begin
            bit raw, stg;
            m_chg[n] = 1'b0;
            if (!ce) continue;
            raw = (n == 2) ? (i8 == 8'h00) : (i5 == 5'b11111);
            m_hist[n] = {m_hist[n][2:0], raw};
            stg = m_hist[n][MP[n]];
            if (m_ns[n] >= MP[n]) begin
                m_ov[n] = 1'b1;
                if (stg == m_o[n]) m_run[n] = 0;
                else begin
                    m_run[n]++;
                    if (m_run[n] == MF[n] + 1) begin
                        m_o[n] = stg; m_run[n] = 0; m_chg[n] = 1'b1;
                    end
                end
            end
            if (m_ns[n] < 8) m_ns[n]++;
        end
    endtask

    task automatic step(input logic [4:0] i5, input logic [7:0] i8, input logic ce);
        I = i5; I8 = i8; CE = ce;
        @(posedge C);
        model_edge(i5, i8, ce);
        #1;
    endtask

    task automatic do_reset();
        @(negedge C);
        CLRN = 1'b0;
        model_reset();
        #2 CLRN = 1'b1;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({O, OV, CHG, O1, OV1} !== 5'b00010) begin
            n_fail++; $display("FAIL reset_initial: got %b want 00010", {O, OV, CHG, O1, OV1});
        end
        CLRN = 1'b1;
        for (int k = 0; k < 4; k++) step(5'b11111, 8'h00, 1'b1);
        n_tests++;
        if ({O, O8} !== 2'b11) begin
            n_fail++; $display("FAIL reset_preload: got %b want 11", {O, O8});
        end
        #2 CLRN = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({O, OV, CHG, O1, OV1, O8, OV8} !== 7'b0001000) begin
            n_fail++; $display("FAIL reset_async: got %b want 0001000", {O, OV, CHG, O1, OV1, O8, OV8});
        end
        #1 CLRN = 1'b1;
    endtask

    task automatic test_latency();
        logic [4:0] got, want;
        do_reset();
        for (int e = 1; e <= 5; e++) begin
            step(5'b11111, 8'hFF, 1'b1);
            got  = {OV, O, CHG, 2'b00};
            want = {(e >= 2), (e >= 4), (e == 4), 2'b00};
            n_tests++;
            if (got !== want) begin
                n_fail++; $display("FAIL latency_edge%0d: got OV,O,CHG=%b want %b", e, got[4:2], want[4:2]);
            end
        end
    endtask

    task automatic test_glitch();
        bit bad = 1'b0;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            step(5'b11111, 8'hFF, 1'b1);
            if (O !== 1'b0 || CHG !== 1'b0) bad = 1'b1;
        end
        for (int k = 0; k < 6; k++) begin
            step(5'b11110, 8'hFF, 1'b1);
            if (O !== 1'b0 || CHG !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL glitch_reject: O or CHG moved, O=%b CHG=%b want 0 0", O, CHG);
        end
        for (int k = 1; k <= 4; k++) begin
            step(5'b11111, 8'hFF, 1'b1);
            n_tests++;
            if (O !== (k == 4)) begin
                n_fail++; $display("FAIL glitch_pass_%0d: got O=%b want %b", k, O, (k == 4));
            end
        end
    endtask

    task automatic test_clock_enable();
        bit bad = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) step(5'b11111, 8'hFF, 1'b1);
        n_tests++;
        if (u_dut.r_cnt !== 2'd2) begin
            n_fail++; $display("FAIL ce_precount: got cnt=%0d want 2", u_dut.r_cnt);
        end
        for (int k = 0; k < 10; k++) begin
            step(5'b11111, 8'hFF, 1'b0);
            if (O !== 1'b0 || CHG !== 1'b0 || u_dut.r_cnt !== 2'd2) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL ce_hold: O=%b CHG=%b cnt=%0d want 0 0 2", O, CHG, u_dut.r_cnt);
        end
        step(5'b11111, 8'hFF, 1'b1);
        n_tests++;
        if ({O, CHG} !== 2'b11) begin
            n_fail++; $display("FAIL ce_resume: got O,CHG=%b want 11", {O, CHG});
        end
    endtask

    task automatic test_wide();
        do_reset();
        step(5'b0, 8'h00, 1'b1);
        n_tests++;
        if ({O8, OV8, CHG8} !== 3'b111) begin
            n_fail++; $display("FAIL wide_first: got O,OV,CHG=%b want 111", {O8, OV8, CHG8});
        end
        step(5'b0, 8'h01, 1'b1);
        n_tests++;
        if ({O8, CHG8} !== 2'b01) begin
            n_fail++; $display("FAIL wide_drop: got O,CHG=%b want 01", {O8, CHG8});
        end
        step(5'b0, 8'h80, 1'b1);
        n_tests++;
        if ({O8, CHG8} !== 2'b00) begin
            n_fail++; $display("FAIL wide_msb: got O,CHG=%b want 00", {O8, CHG8});
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 3; k++) step(5'b11111, 8'hFF, 1'b1);
        #2 CLRN = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({O, OV, CHG} !== 3'b000 || u_dut.r_cnt !== 2'd0 || u_dut.g_pipe.r_vld_pipe !== 1'b0) begin
            n_fail++; $display("FAIL midreset_clear: O,OV,CHG=%b cnt=%0d vld=%b want 000 0 0",
                               {O, OV, CHG}, u_dut.r_cnt, u_dut.g_pipe.r_vld_pipe);
        end
        #1 CLRN = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step(5'b11111, 8'hFF, 1'b1);
            n_tests++;
            if (O !== (e == 4)) begin
                n_fail++; $display("FAIL midreset_latency_%0d: got O=%b want %b", e, O, (e == 4));
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] i5 = 5'b11111;
        logic [7:0] i8 = 8'h00;
        int         hold = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                i5   = ($urandom_range(0, 1) == 0) ? 5'b11111 : 5'($urandom);
                i8   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
                hold = $urandom_range(1, 6);
            end
            hold--;
            step(i5, i8, $urandom_range(0, 9) != 0);
            n_tests++;
            if ({O, OV, CHG} !== {m_o[0], m_ov[0], m_chg[0]}) begin
                n_fail++; $display("FAIL rand_default c=%0d: got %b want %b", c, {O, OV, CHG}, {m_o[0], m_ov[0], m_chg[0]});
            end
            n_tests++;
            if ({O1, OV1, CHG1} !== {m_o[1], m_ov[1], m_chg[1]}) begin
                n_fail++; $display("FAIL rand_init1 c=%0d: got %b want %b", c, {O1, OV1, CHG1}, {m_o[1], m_ov[1], m_chg[1]});
            end
            n_tests++;
            if ({O8, OV8, CHG8} !== {m_o[2], m_ov[2], m_chg[2]}) begin
                n_fail++; $display("FAIL rand_wide c=%0d: got %b want %b", c, {O8, OV8, CHG8}, {m_o[2], m_ov[2], m_chg[2]});
            end
            if ($urandom_range(0, 59) == 0) begin
                #1 CLRN = 1'b0;
                model_reset();
                #1 CLRN = 1'b1;
            end
        end
    endtask

    initial begin
        CLRN = 1'b0; CE = 1'b0; I = '0; I8 = '0;
        model_reset();
        #12;
        test_reset();
        test_latency();
        test_glitch();
        test_clock_enable();
        test_wide();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
